fb_rd_ctrl: RTL and testbench
=============================

FB_RD_CTRL -- requirements
Module: fb_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the pixel/memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 29, the memory word address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16 (power of 2, at least 4), the prefetch FIFO entry count.
REQ-004 SHALL have parameter TIMEOUT, default 64, the read-response watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse that starts a frame fetch.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH bits: first word address of the frame, sampled on frame_start.
REQ-009 SHALL have port frame_len, input, ADDR_WIDTH bits: number of words in the frame, sampled on frame_start.
REQ-010 SHALL have port rd_addr, output, ADDR_WIDTH bits: memory read address.
REQ-011 SHALL have port rd_en, output, 1 bit: memory read enable, active-low.
REQ-012 SHALL have port rd_data, input, DATA_WIDTH bits: memory read data.
REQ-013 SHALL have port rd_data_valid, input, 1 bit: active-high one-cycle strobe qualifying rd_data.
REQ-014 SHALL have port pix_data, output, DATA_WIDTH bits: FIFO head word.
REQ-015 SHALL have port pix_valid, output, 1 bit: pix_data is valid.
REQ-016 SHALL have port pix_ready, input, 1 bit: the downstream consumer accepts a word.
REQ-017 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last word of the frame is consumed.
REQ-019 SHALL have port underflow, output, 1 bit: sticky flag for pix_ready while the FIFO is empty and busy.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and DRAIN.
REQ-021 SHALL, in IDLE, on frame_start with frame_len != 0, latch base_addr and frame_len and go to ISSUE; SHALL ignore frame_start when frame_len = 0.
REQ-022 SHALL, in ISSUE, drive rd_en = 0 with rd_addr at the current address when free_slots > 0, then go to WAIT; otherwise it SHALL hold rd_en = 1 and stay in ISSUE.
REQ-023 SHALL define free_slots as FIFO_DEPTH minus occupancy minus outstanding reads; at most 1 read SHALL be outstanding.
REQ-024 SHALL, in WAIT, hold rd_en = 0 and rd_addr stable until rd_data_valid = 1.
REQ-025 SHALL, on rd_data_valid in WAIT, push rd_data into the FIFO in the same edge, increment the address and decrement the remaining count, then drive rd_en = 1 for at least 1 cycle.
REQ-026 SHALL, after that response, go to ISSUE if remaining > 0, else to DRAIN.
REQ-027 SHALL ignore rd_data_valid outside WAIT: no push and no error.
REQ-028 SHALL wrap the address modulo 2^ADDR_WIDTH.
REQ-029 SHALL issue no duplicate reads within a frame, since the memory drops a read to an unchanged address.
REQ-030 SHALL, in DRAIN, return to IDLE when the FIFO becomes empty, pulsing frame_done in the cycle the last word is popped.
REQ-031 SHALL pop the FIFO on pix_valid and pix_ready; pix_valid SHALL equal not-empty.
REQ-032 SHALL show zero latency from push to pix_valid in the next cycle.
REQ-033 SHALL, on a simultaneous push and pop with the FIFO full, pop first so the push succeeds; the FIFO SHALL never overflow, by construction via free_slots.
REQ-034 SHALL ignore frame_start while busy.
REQ-035 SHALL set busy = 1 in every state other than IDLE.
REQ-036 SHALL set underflow when pix_ready = 1, the FIFO is empty and busy = 1; underflow SHALL stay set until reset.

Reset
REQ-037 SHALL, on reset, force state IDLE, rd_en = 1, rd_addr = 0, FIFO empty, pix_valid = 0, pix_data = 0, busy = 0, frame_done = 0, underflow = 0, and outstanding = 0.
REQ-038 SHALL, on reset mid-frame, abort the frame and discard both the FIFO contents and any late rd_data_valid.

Configuration
REQ-039 SHALL compile in the read-response watchdog when the macro FB_RD_TIMEOUT_EN is defined.
REQ-040 SHALL, with FB_RD_TIMEOUT_EN defined, count WAIT cycles and, after TIMEOUT cycles without rd_data_valid, drive rd_en = 1 for 1 cycle and re-enter ISSUE at the same address.
REQ-041 SHALL, with FB_RD_TIMEOUT_EN defined, set a sticky output rd_timeout, cleared by reset.
REQ-042 SHALL, without FB_RD_TIMEOUT_EN, not have the port rd_timeout and SHALL wait in WAIT indefinitely.

Structure
REQ-043 SHALL take the state enum (IDLE/ISSUE/WAIT/DRAIN), the ASSERT_L/DEASSERT_L constants and the default widths from the shared package fb_pkg.
REQ-044 SHALL implement the FIFO as the sub-module fb_sync_fifo, with parameters DATA_WIDTH and FIFO_DEPTH and an occupancy count output.

Verification
REQ-045 SHALL verify: base_addr = 0x100, frame_len = 8, pix_ready = 1, memory responding after 2 cycles -> rd_addr sequence 0x100 to 0x107, 8 pixels in order, 1 frame_done pulse, underflow = 0.
REQ-046 SHALL verify: FIFO_DEPTH = 4, frame_len = 20, pix_ready = 0 for 50 cycles -> exactly 4 words buffered, rd_en held at 1, no overflow; then pix_ready = 1 -> all 20 words delivered.
REQ-047 SHALL verify: base_addr = 2^29 - 2, frame_len = 4 -> addresses 0x1FFFFFFE, 0x1FFFFFFF, 0x0, 0x1.
REQ-048 SHALL verify: pix_ready = 1 while empty in the cycle after frame_start -> underflow = 1 and sticky; frame_start while busy -> ignored.
REQ-049 SHALL verify: reset asserted mid-frame with 1 read outstanding, then a late rd_data_valid -> all outputs at reset values, no pix_valid.
REQ-050 SHALL verify, with FB_RD_TIMEOUT_EN defined: memory drops the 3rd read -> after 64 cycles the read is re-issued at the same address, rd_timeout = 1, and the frame completes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer read path: FSM states, active-low
// strobe levels and default widths.
package fb_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 29;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned TIMEOUT_DEF    = 64;

    // Memory read enable is active-low.
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain
    } fb_state_e;

endpackage

// File: rtl/fb_sync_fifo.sv
// Prefetch FIFO for fb_rd_ctrl: first-word-fall-through, head word reads as
// zero when empty, and a simultaneous push/pop on a full FIFO is accepted.
module fb_sync_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic [CntW-1:0]       o_count
);

    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CntW-2:0]       r_wr_ptr;
    logic [CntW-2:0]       r_rd_ptr;
    logic [CntW-1:0]       r_count;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == DepthC);
    assign w_pop   = i_pop && !o_empty;
    // Pop frees the slot first, so a push into a full FIFO still lands.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents need no reset since o_data is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_rd_ctrl.sv
// Frame-buffer read controller: fetches frame_len words starting at base_addr,
// one outstanding read at a time, into a prefetch FIFO feeding a pixel stream.
// Optional read-response watchdog: define FB_RD_TIMEOUT_EN.
module fb_rd_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] frame_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done,
`ifdef FB_RD_TIMEOUT_EN
    output logic                  rd_timeout,
`endif
    output logic                  underflow
);

    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
        $error("fb_rd_ctrl: FIFO_DEPTH must be a power of 2 >= 4 and TIMEOUT nonzero");
    end

    fb_state_e             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_remain, w_remain_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic                  r_outstanding, w_outstanding_nxt;
    logic                  r_underflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [CntW-1:0]       w_count;
    logic [CntW-1:0]       w_free;

`ifdef FB_RD_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    logic [WaitW-1:0] r_wait_cnt;
    logic             r_timeout;
    logic             w_timeout_hit;

    assign w_timeout_hit = (r_state == StWait) && !rd_data_valid && (r_wait_cnt == WaitLast);
    assign rd_timeout    = r_timeout;
`endif

    assign busy      = (r_state != StIdle);
    assign pix_valid = !w_empty;
    assign w_pop     = pix_ready && !w_empty;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_addr;
    assign underflow = r_underflow;
    // Reads in flight count against capacity so a response always has a slot.
    assign w_free    = DepthC - w_count - CntW'(r_outstanding);
    // The last word leaves only in DRAIN: nothing is pushed after entering it.
    assign frame_done = (r_state == StDrain) && w_pop && (w_count == CntW'(1));

    fb_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_data (rd_data),
        .i_pop  (w_pop),
        .o_data (pix_data),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    // Next-state logic: issue one read, wait for its response, repeat, then drain.
    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_remain_nxt      = r_remain;
        w_rd_en_nxt       = r_rd_en;
        w_outstanding_nxt = r_outstanding;
        w_push            = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (frame_start && (frame_len != '0)) begin
                    w_addr_nxt   = base_addr;
                    w_remain_nxt = frame_len;
                    w_state_nxt  = StIssue;
                end
            end
            StIssue: begin
                if (w_free != '0) begin
                    w_rd_en_nxt       = ASSERT_L;
                    w_outstanding_nxt = 1'b1;
                    w_state_nxt       = StWait;
                end
            end
            StWait: begin
                if (rd_data_valid) begin
                    w_push            = 1'b1;
                    w_addr_nxt        = r_addr + ADDR_WIDTH'(1);
                    w_remain_nxt      = r_remain - ADDR_WIDTH'(1);
                    w_rd_en_nxt       = DEASSERT_L;
                    w_outstanding_nxt = 1'b0;
                    w_state_nxt       = (r_remain == ADDR_WIDTH'(1)) ? StDrain : StIssue;
                end
`ifdef FB_RD_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    // Release rd_en so the retry at the same address is a fresh read.
                    w_rd_en_nxt       = DEASSERT_L;
                    w_outstanding_nxt = 1'b0;
                    w_state_nxt       = StIssue;
                end
`endif
            end
            StDrain: begin
                if (w_empty || (w_pop && (w_count == CntW'(1)))) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_remain      <= '0;
            r_rd_en       <= DEASSERT_L;
            r_outstanding <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_remain      <= w_remain_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_outstanding <= w_outstanding_nxt;
        end
    end

    // Sticky underflow: consumer asked for data mid-frame while nothing was buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (pix_ready && w_empty && busy) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef FB_RD_TIMEOUT_EN
    // Watchdog: count cycles spent waiting on the current read; flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= (w_state_nxt == StWait && r_state == StWait) ?
                          r_wait_cnt + 1'b1 : '0;
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_rd_ctrl.sv
// Directed bench for fb_rd_ctrl (FIFO_DEPTH = 4). Memory model answers each new
// read two cycles after it is seen; define FB_RD_TIMEOUT_EN to add the retry case.
module tb_fb_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [28:0] base_addr;
    logic [28:0] frame_len;
    logic [28:0] rd_addr;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic        rd_data_valid;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;
    logic        underflow;
`ifdef FB_RD_TIMEOUT_EN
    logic        rd_timeout;
`endif

    int checks = 0;
    int errors = 0;

    // Stimulus-side controls
    logic        r_force = 1'b0;
    logic        r_auto = 1'b0;
    logic        r_mem_en = 1'b1;
    logic        r_late_valid = 1'b0;
    logic        r_drop_arm = 1'b0;
    logic [28:0] r_drop_addr = '0;

    // Monitor / memory-model state
    logic        r_mem_valid = 1'b0;
    logic        r_mem_pend = 1'b0;
    int          r_mem_cnt = 0;
    logic [28:0] r_mem_addr = '0;
    logic        r_dropped = 1'b0;
    logic        r_prev_en = 1'b1;
    logic [28:0] r_prev_addr = '0;
    int          r_cyc = 0;
    int          r_stab_err = 0;
    int          r_fd_cnt = 0;
    logic [28:0] iss_q[$];
    int          iss_cyc_q[$];
    logic [31:0] pix_q[$];

    assign pix_ready     = r_force | (r_auto & pix_valid);
    assign rd_data_valid = r_mem_valid | r_late_valid;

    fb_rd_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(29),
        .FIFO_DEPTH(4),
        .TIMEOUT   (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .base_addr    (base_addr),
        .frame_len    (frame_len),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .busy         (busy),
        .frame_done   (frame_done),
`ifdef FB_RD_TIMEOUT_EN
        .rd_timeout   (rd_timeout),
`endif
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Memory model and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        r_cyc       <= r_cyc + 1;
        r_prev_en   <= rd_en;
        r_prev_addr <= rd_addr;
        r_mem_valid <= 1'b0;
        if (rd_en === 1'b0 && r_prev_en === 1'b0 && rd_addr !== r_prev_addr) begin
            r_stab_err <= r_stab_err + 1;
        end
        if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
            pix_q.push_back(pix_data);
        end
        if (frame_done === 1'b1) begin
            r_fd_cnt <= r_fd_cnt + 1;
        end
        if (reset || !r_mem_en) begin
            r_mem_pend <= 1'b0;
        end else if (rd_en === 1'b0 && r_prev_en === 1'b1) begin
            iss_q.push_back(rd_addr);
            iss_cyc_q.push_back(r_cyc);
            if (r_drop_arm && !r_dropped && rd_addr == r_drop_addr) begin
                r_dropped <= 1'b1;
            end else begin
                r_mem_pend <= 1'b1;
                r_mem_cnt  <= 1;
                r_mem_addr <= rd_addr;
            end
        end else if (r_mem_pend) begin
            if (r_mem_cnt == 0) begin
                r_mem_valid <= 1'b1;
                rd_data     <= {3'b101, r_mem_addr};
                r_mem_pend  <= 1'b0;
            end else begin
                r_mem_cnt <= r_mem_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic start(input logic [28:0] base, input logic [28:0] len);
        base_addr   = base;
        frame_len   = len;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        step(1);
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd1);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check({tag, "_pix_data"}, 64'(pix_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_underflow"}, 64'(underflow), 64'd0);
`ifdef FB_RD_TIMEOUT_EN
        check({tag, "_rd_timeout"}, 64'(rd_timeout), 64'd0);
`endif
    endtask

    initial begin
        int ib;
        int ip;
        int fd0;
        logic [28:0] a;

        reset       = 1'b1;
        frame_start = 1'b0;
        base_addr   = '0;
        frame_len   = '0;
        step(3);
        reset = 1'b0;
        check_reset_outputs("reset");

        // frame_len = 0 is ignored
        start(29'h123, 29'd0);
        step(3);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_no_read", 64'(iss_q.size()), 64'd0);

        // Basic frame: 8 words from 0x100, consumer always ready when data present
        ib = iss_q.size(); ip = pix_q.size(); fd0 = r_fd_cnt;
        r_auto = 1'b1;
        start(29'h100, 29'd8);
        check("basic_busy", 64'(busy), 64'd1);
        wait_idle("basic_idle", 300);
        check("basic_nreads", 64'(iss_q.size() - ib), 64'd8);
        check("basic_npix", 64'(pix_q.size() - ip), 64'd8);
        for (int i = 0; i < 8; i++) begin
            a = 29'h100 + 29'(i);
            check($sformatf("basic_addr%0d", i), 64'(iss_q[ib + i]), 64'(a));
            check($sformatf("basic_pix%0d", i), 64'(pix_q[ip + i]), 64'({3'b101, a}));
        end
        check("basic_done_pulses", 64'(r_fd_cnt - fd0), 64'd1);
        check("basic_underflow", 64'(underflow), 64'd0);
        check("basic_rd_en_idle", 64'(rd_en), 64'd1);

        // Backpressure: depth 4, 20 words, consumer stalled 50 cycles
        do_reset();
        r_auto = 1'b0;
        ib = iss_q.size(); ip = pix_q.size(); fd0 = r_fd_cnt;
        start(29'h200, 29'd20);
        step(50);
        check("bp_reads_held", 64'(iss_q.size() - ib), 64'd4);
        check("bp_rd_en_high", 64'(rd_en), 64'd1);
        check("bp_pix_valid", 64'(pix_valid), 64'd1);
        check("bp_head", 64'(pix_data), 64'({3'b101, 29'h200}));
        check("bp_no_pop", 64'(pix_q.size() - ip), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        r_auto = 1'b1;
        wait_idle("bp_idle", 600);
        check("bp_nreads", 64'(iss_q.size() - ib), 64'd20);
        check("bp_npix", 64'(pix_q.size() - ip), 64'd20);
        for (int i = 0; i < 20; i++) begin
            a = 29'h200 + 29'(i);
            check($sformatf("bp_pix%0d", i), 64'(pix_q[ip + i]), 64'({3'b101, a}));
        end
        check("bp_done_pulses", 64'(r_fd_cnt - fd0), 64'd1);

        // Address wrap at 2^29
        do_reset();
        ib = iss_q.size(); ip = pix_q.size();
        start(29'h1FFF_FFFE, 29'd4);
        wait_idle("wrap_idle", 300);
        check("wrap_nreads", 64'(iss_q.size() - ib), 64'd4);
        check("wrap_addr0", 64'(iss_q[ib]), 64'h1FFF_FFFE);
        check("wrap_addr1", 64'(iss_q[ib + 1]), 64'h1FFF_FFFF);
        check("wrap_addr2", 64'(iss_q[ib + 2]), 64'h0);
        check("wrap_addr3", 64'(iss_q[ib + 3]), 64'h1);
        check("wrap_pix2", 64'(pix_q[ip + 2]), 64'({3'b101, 29'h0}));

        // Underflow on early ready; frame_start while busy ignored
        do_reset();
        r_auto = 1'b0;
        ib = iss_q.size(); fd0 = r_fd_cnt;
        start(29'h300, 29'd3);
        check("uf_before", 64'(underflow), 64'd0);
        r_force = 1'b1;
        step(1);
        r_force = 1'b0;
        r_auto  = 1'b1;
        check("uf_set", 64'(underflow), 64'd1);
        start(29'h700, 29'd5);
        wait_idle("uf_idle", 300);
        step(5);
        check("uf_sticky", 64'(underflow), 64'd1);
        check("busy_start_ignored_busy", 64'(busy), 64'd0);
        check("busy_start_nreads", 64'(iss_q.size() - ib), 64'd3);
        check("busy_start_last_addr", 64'(iss_q[iss_q.size() - 1]), 64'h302);
        check("uf_done_pulses", 64'(r_fd_cnt - fd0), 64'd1);

        // Reset mid-frame with a read outstanding, then a late response
        do_reset();
        r_mem_en = 1'b0;
        start(29'h400, 29'd8);
        step(3);
        check("mid_outstanding", 64'(rd_en), 64'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        r_late_valid = 1'b1;
        step(1);
        r_late_valid = 1'b0;
        check_reset_outputs("midrst");
        step(3);
        check("midrst_no_pix", 64'(pix_valid), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);
        r_mem_en = 1'b1;

`ifdef FB_RD_TIMEOUT_EN
        // Memory drops the third read; the watchdog retries the same address
        do_reset();
        ib = iss_q.size(); ip = pix_q.size(); fd0 = r_fd_cnt;
        r_drop_addr = 29'h502;
        r_drop_arm  = 1'b1;
        start(29'h500, 29'd5);
        wait_idle("to_idle", 500);
        check("to_flag", 64'(rd_timeout), 64'd1);
        check("to_nreads", 64'(iss_q.size() - ib), 64'd6);
        check("to_addr2", 64'(iss_q[ib + 2]), 64'h502);
        check("to_retry_addr", 64'(iss_q[ib + 3]), 64'h502);
        check("to_retry_gap", 64'(iss_cyc_q[ib + 3] - iss_cyc_q[ib + 2]), 64'd65);
        check("to_addr5", 64'(iss_q[ib + 5]), 64'h504);
        check("to_npix", 64'(pix_q.size() - ip), 64'd5);
        for (int i = 0; i < 5; i++) begin
            a = 29'h500 + 29'(i);
            check($sformatf("to_pix%0d", i), 64'(pix_q[ip + i]), 64'({3'b101, a}));
        end
        check("to_done_pulses", 64'(r_fd_cnt - fd0), 64'd1);
        r_drop_arm = 1'b0;
`endif

        check("rd_addr_stable_in_wait", 64'(r_stab_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
